// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decoded operands and control for the execute stage,
// supports stall (hold), flush (bubble insert) and counts inserted bubbles with saturation.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ID_Valid,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExtImm,
    input  logic              ID_ZeroExt,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [9:0]        ID_Ctrl,
    output logic              EX_Valid,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [9:0]        EX_Ctrl,
    output logic [CNT_W-1:0]  BubbleCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              valid_r,  valid_s;
    logic [DATA_W-1:0] pc4_r,    pc4_s;
    logic [DATA_W-1:0] rd1_r,    rd1_s;
    logic [DATA_W-1:0] rd2_r,    rd2_s;
    logic [DATA_W-1:0] imm_r,    imm_s;
    logic [4:0]        rs_r,     rs_s;
    logic [4:0]        rt_r,     rt_s;
    logic [4:0]        rd_r,     rd_s;
    logic [9:0]        ctrl_r,   ctrl_s;
    logic [CNT_W-1:0]  bub_cnt_r, bub_cnt_s;
    logic              bubble_write_s;
    logic [DATA_W-1:0] imm_sel_s;

    // Immediate selection: zero-extended low half for logical ops, sign-extended value otherwise
    always_comb begin
        imm_sel_s = ID_SignExtImm;
        if (ID_ZeroExt) begin
            imm_sel_s = {{(DATA_W-16){1'b0}}, ID_SignExtImm[15:0]};
        end else begin
            imm_sel_s = ID_SignExtImm;
        end
    end

    // Next-state selection; flush outranks stall, stall holds, otherwise load
    always_comb begin
        valid_s        = valid_r;
        pc4_s          = pc4_r;
        rd1_s          = rd1_r;
        rd2_s          = rd2_r;
        imm_s          = imm_r;
        rs_s           = rs_r;
        rt_s           = rt_r;
        rd_s           = rd_r;
        ctrl_s         = ctrl_r;
        bubble_write_s = 1'b0;
        if (Flush) begin
            valid_s        = 1'b0;
            pc4_s          = '0;
            rd1_s          = '0;
            rd2_s          = '0;
            imm_s          = '0;
            rs_s           = 5'd0;
            rt_s           = 5'd0;
            rd_s           = 5'd0;
            ctrl_s         = 10'd0;
            bubble_write_s = 1'b1;
        end else if (Stall) begin
            bubble_write_s = 1'b0;
        end else begin
            valid_s        = ID_Valid;
            pc4_s          = ID_PCPlus4;
            rd1_s          = ID_ReadData1;
            rd2_s          = ID_ReadData2;
            imm_s          = imm_sel_s;
            rs_s           = ID_Rs;
            rt_s           = ID_Rt;
            rd_s           = ID_Rd;
            // An invalid instruction still carries its data but must not act on machine state
            ctrl_s         = ID_Valid ? ID_Ctrl : 10'd0;
            bubble_write_s = ~ID_Valid;
        end
    end

    // Saturating bubble counter next value
    always_comb begin
        bub_cnt_s = bub_cnt_r;
        if (bubble_write_s && (bub_cnt_r != CNT_MAX)) begin
            bub_cnt_s = bub_cnt_r + CNT_ONE;
        end else begin
            bub_cnt_s = bub_cnt_r;
        end
    end

    // Stage register with synchronous reset overriding everything
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_r   <= 1'b0;
            pc4_r     <= '0;
            rd1_r     <= '0;
            rd2_r     <= '0;
            imm_r     <= '0;
            rs_r      <= 5'd0;
            rt_r      <= 5'd0;
            rd_r      <= 5'd0;
            ctrl_r    <= 10'd0;
            bub_cnt_r <= '0;
        end else begin
            valid_r   <= valid_s;
            pc4_r     <= pc4_s;
            rd1_r     <= rd1_s;
            rd2_r     <= rd2_s;
            imm_r     <= imm_s;
            rs_r      <= rs_s;
            rt_r      <= rt_s;
            rd_r      <= rd_s;
            ctrl_r    <= ctrl_s;
            bub_cnt_r <= bub_cnt_s;
        end
    end

    assign EX_Valid     = valid_r;
    assign EX_PCPlus4   = pc4_r;
    assign EX_ReadData1 = rd1_r;
    assign EX_ReadData2 = rd2_r;
    assign EX_Imm       = imm_r;
    assign EX_Rs        = rs_r;
    assign EX_Rt        = rt_r;
    assign EX_Rd        = rd_r;
    assign EX_Ctrl      = ctrl_r;
    assign BubbleCount  = bub_cnt_r;

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage; a CNT_W=4 twin checks saturation.
module tb_id_ex_register;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, ID_Valid, ID_ZeroExt;
    logic [31:0] ID_PCPlus4, ID_ReadData1, ID_ReadData2, ID_SignExtImm;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
    logic [9:0]  ID_Ctrl;

    logic        EX_Valid, s_Valid;
    logic [31:0] EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_Imm;
    logic [31:0] s_PCPlus4, s_ReadData1, s_ReadData2, s_Imm;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rd, s_Rs, s_Rt, s_Rd;
    logic [9:0]  EX_Ctrl, s_Ctrl;
    logic [15:0] BubbleCount;
    logic [3:0]  s_BubbleCount;

    int tests_run = 0;
    int tests_failed = 0;

    // behavioural model state
    logic        m_valid;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [9:0]  m_ctrl;
    int          m_bubbles;

    always #5 Clk = ~Clk;

    id_ex_register dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ID_Valid(ID_Valid),
        .ID_PCPlus4(ID_PCPlus4), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_SignExtImm(ID_SignExtImm), .ID_ZeroExt(ID_ZeroExt),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Ctrl(ID_Ctrl),
        .EX_Valid(EX_Valid), .EX_PCPlus4(EX_PCPlus4), .EX_ReadData1(EX_ReadData1),
        .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
        .EX_Rd(EX_Rd), .EX_Ctrl(EX_Ctrl), .BubbleCount(BubbleCount)
    );

    id_ex_register #(.DATA_W(32), .CNT_W(4)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ID_Valid(ID_Valid),
        .ID_PCPlus4(ID_PCPlus4), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_SignExtImm(ID_SignExtImm), .ID_ZeroExt(ID_ZeroExt),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Ctrl(ID_Ctrl),
        .EX_Valid(s_Valid), .EX_PCPlus4(s_PCPlus4), .EX_ReadData1(s_ReadData1),
        .EX_ReadData2(s_ReadData2), .EX_Imm(s_Imm), .EX_Rs(s_Rs), .EX_Rt(s_Rt),
        .EX_Rd(s_Rd), .EX_Ctrl(s_Ctrl), .BubbleCount(s_BubbleCount)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic rand_id();
        ID_Valid      = ($urandom_range(3, 0) != 0);
        ID_ZeroExt    = $urandom_range(1, 0) != 0;
        ID_PCPlus4    = $urandom;
        ID_ReadData1  = $urandom;
        ID_ReadData2  = $urandom;
        ID_SignExtImm = $urandom;
        ID_Rs         = 5'($urandom);
        ID_Rt         = 5'($urandom);
        ID_Rd         = 5'($urandom);
        ID_Ctrl       = 10'($urandom);
    endtask

    // Advance one edge, update model from the rules, compare every output of both instances
    task automatic tick();
        @(posedge Clk);
        #1;
        if (Reset) begin
            {m_valid, m_pc, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd, m_ctrl} = '0;
            m_bubbles = 0;
        end else if (Flush) begin
            {m_valid, m_pc, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd, m_ctrl} = '0;
            m_bubbles++;
        end else if (!Stall) begin
            m_valid = ID_Valid;
            m_pc    = ID_PCPlus4;
            m_rd1   = ID_ReadData1;
            m_rd2   = ID_ReadData2;
            m_imm   = ID_ZeroExt ? (ID_SignExtImm & 32'h0000FFFF) : ID_SignExtImm;
            m_rs    = ID_Rs;
            m_rt    = ID_Rt;
            m_rd    = ID_Rd;
            m_ctrl  = ID_Valid ? ID_Ctrl : 10'd0;
            if (!ID_Valid) m_bubbles++;
        end
        check_val("valid", 64'(EX_Valid), 64'(m_valid));
        check_val("pc4",   64'(EX_PCPlus4), 64'(m_pc));
        check_val("rd1",   64'(EX_ReadData1), 64'(m_rd1));
        check_val("rd2",   64'(EX_ReadData2), 64'(m_rd2));
        check_val("imm",   64'(EX_Imm), 64'(m_imm));
        check_val("regs",  64'({EX_Rs, EX_Rt, EX_Rd}), 64'({m_rs, m_rt, m_rd}));
        check_val("ctrl",  64'(EX_Ctrl), 64'(m_ctrl));
        check_val("bubcnt", 64'(BubbleCount), 64'((m_bubbles > 65535) ? 65535 : m_bubbles));
        check_val("sat_bubcnt", 64'(s_BubbleCount), 64'((m_bubbles > 15) ? 15 : m_bubbles));
        check_val("sat_ctrl", 64'({s_Valid, s_Ctrl, s_Imm}), 64'({m_valid, m_ctrl, m_imm}));
    endtask

    int    prev_cnt;
    logic [31:0] held_pc;

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        rand_id();
        m_bubbles = 0;
        tick();
        tick();
        check_val("reset_bubcnt", 64'(BubbleCount), 64'd0);
        check_val("reset_valid", 64'(EX_Valid), 64'd0);

        // Normal load
        Reset = 1'b0;
        rand_id();
        ID_Valid = 1'b1; ID_SignExtImm = 32'hFFFF8004; ID_ZeroExt = 1'b0; ID_Ctrl = 10'h3A5;
        tick();
        check_val("load_imm", 64'(EX_Imm), 64'h0000_0000_FFFF_8004);
        check_val("load_ctrl", 64'(EX_Ctrl), 64'h3A5);
        check_val("load_valid", 64'(EX_Valid), 64'd1);
        check_val("load_bubcnt", 64'(BubbleCount), 64'd0);

        // Zero-extend
        ID_ZeroExt = 1'b1;
        tick();
        check_val("zext_imm", 64'(EX_Imm), 64'h0000_0000_0000_8004);

        // Stall three cycles with changing inputs
        held_pc = EX_PCPlus4;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            ID_Valid = 1'b0;
            tick();
            check_val("stall_ctrl", 64'(EX_Ctrl), 64'h3A5);
            check_val("stall_pc", 64'(EX_PCPlus4), 64'(held_pc));
        end
        Stall = 1'b0;
        rand_id();
        ID_Valid = 1'b1;
        tick();

        // Stall and flush together
        prev_cnt = int'(BubbleCount);
        Stall = 1'b1; Flush = 1'b1; ID_Ctrl = 10'h3FF; ID_Valid = 1'b1;
        tick();
        check_val("sf_ctrl", 64'(EX_Ctrl), 64'd0);
        check_val("sf_data", 64'(EX_ReadData1 | EX_ReadData2 | EX_Imm | EX_PCPlus4), 64'd0);
        check_val("sf_bubcnt", 64'(BubbleCount), 64'(prev_cnt + 1));
        Stall = 1'b0;

        // Twenty consecutive flushes saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            rand_id();
            tick();
            check_val("sat_nonzero", 64'(s_BubbleCount != 4'h0), 64'd1);
        end
        check_val("sat_final", 64'(s_BubbleCount), 64'hF);
        Flush = 1'b0;

        // Reset in the middle of a stall
        rand_id();
        ID_Valid = 1'b1; ID_Ctrl = 10'h155;
        tick();
        Stall = 1'b1;
        rand_id();
        tick();
        check_val("held_155", 64'(EX_Ctrl), 64'h155);
        Reset = 1'b1;
        tick();
        check_val("rst_stall_all", 64'(EX_Ctrl | EX_Valid | EX_PCPlus4 | EX_Imm | BubbleCount), 64'd0);
        Reset = 1'b0; Stall = 1'b0;
        rand_id();
        ID_Valid = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            Reset = ($urandom_range(49, 0) == 0);
            Stall = ($urandom_range(3, 0) == 0);
            Flush = ($urandom_range(7, 0) == 0);
            rand_id();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
